// File: rtl/te_window_feeder.sv
// Window sequencer between the connector FIFO and the itype detector.
// Presents a sliding lc/tc/nc window and holds tc until its successor is known.
package mure_pkg;
  typedef struct packed {
    logic        valid;
    logic [3:0]  itype;
    logic [31:0] pc;
    logic [31:0] tval;
  } fifo_entry_s;
endpackage

module te_window_feeder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  mure_pkg::fifo_entry_s in_entry_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  drain_i,
  output mure_pkg::fifo_entry_s lc_fifo_entry_o,
  output mure_pkg::fifo_entry_s tc_fifo_entry_o,
  output mure_pkg::fifo_entry_s nc_fifo_entry_o,
  output logic                  window_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      instr_cnt_o
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  mure_pkg::fifo_entry_s lc_q, lc_d, tc_q, tc_d, nc_q, nc_d, new_entry;
  logic                  consumed_q, consumed_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  raw, win_vld, hs, shift_ok, accept, drain_shift, shift;

  // In DRAIN the bubble behind tc stands in for the missing successor.
  assign raw         = tc_q.valid && (nc_q.valid || state_q == DRAIN);
  assign win_vld     = raw && !consumed_q;
  assign hs          = win_vld && out_ready_i;
  assign shift_ok    = !win_vld || out_ready_i;
  assign in_ready_o  = (state_q != DRAIN) && shift_ok;
  assign accept      = in_valid_i && in_ready_o;
  assign drain_shift = (state_q == DRAIN) && shift_ok;
  assign shift       = accept || drain_shift;

  always_comb begin
    new_entry  = '0;
    lc_d       = lc_q;
    tc_d       = tc_q;
    nc_d       = nc_q;
    consumed_d = consumed_q;
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(hs);
    if (accept) begin
      new_entry       = in_entry_i;
      new_entry.valid = 1'b1;
    end
    if (shift) begin
      // lc only tracks real instructions so repeat-PC checks span trace gaps
      if (tc_q.valid) lc_d = tc_q;
      tc_d       = nc_q;
      nc_d       = new_entry;
      consumed_d = 1'b0;
    end else if (hs) begin
      consumed_d = 1'b1;
    end
    case (state_q)
      IDLE:    if (accept) state_d = PRIME;
      PRIME:   if (accept) state_d = RUN;
               else if (drain_i && !in_valid_i) state_d = DRAIN;
      RUN:     if (drain_i && !in_valid_i) state_d = DRAIN;
      DRAIN:   if (drain_shift && !nc_q.valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lc_q       <= '0;
      tc_q       <= '0;
      nc_q       <= '0;
      consumed_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lc_q       <= lc_d;
      tc_q       <= tc_d;
      nc_q       <= nc_d;
      consumed_q <= consumed_d;
      cnt_q      <= cnt_d;
    end
  end

  assign lc_fifo_entry_o = lc_q;
  assign tc_fifo_entry_o = tc_q;
  assign nc_fifo_entry_o = nc_q;
  assign window_valid_o  = win_vld;
  assign busy_o          = (state_q != IDLE);
  assign instr_cnt_o     = cnt_q;
endmodule

// File: tb/tb_te_window_feeder.sv
// Bench for te_window_feeder: directed vector table, hand sequences for
// backpressure/drain/reset/wrap, then random traffic against a queue model.
module tb_te_window_feeder;
  import mure_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  fifo_entry_s in_entry;
  logic        in_valid, drain, out_ready;
  logic        in_ready, wv, busy;
  fifo_entry_s lc_o, tc_o, nc_o;
  logic [15:0] cnt;
  logic        in_ready4, wv4, busy4;
  fifo_entry_s lc4, tc4, nc4;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_err = 0;

  te_window_feeder dut (
    .clk_i(clk), .rst_ni(rst_n), .in_entry_i(in_entry), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .drain_i(drain), .lc_fifo_entry_o(lc_o),
    .tc_fifo_entry_o(tc_o), .nc_fifo_entry_o(nc_o), .window_valid_o(wv),
    .out_ready_i(out_ready), .busy_o(busy), .instr_cnt_o(cnt));

  te_window_feeder #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_entry_i(in_entry), .in_valid_i(in_valid),
    .in_ready_o(in_ready4), .drain_i(drain), .lc_fifo_entry_o(lc4),
    .tc_fifo_entry_o(tc4), .nc_fifo_entry_o(nc4), .window_valid_o(wv4),
    .out_ready_i(out_ready), .busy_o(busy4), .instr_cnt_o(cnt4));

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chkE(input string name, input fifo_entry_s act, input fifo_entry_s exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic dr, input logic ordy);
    @(negedge clk);
    in_valid    = iv;
    in_entry    = '0;
    in_entry.pc = pc;
    drain       = dr;
    out_ready   = ordy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; drain = 1'b0; out_ready = 1'b1; in_entry = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        dr;
    logic        ordy;
    logic        wv, inr, busy, ncv;
    logic [31:0] tc, nc, lc;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[10];

  // model: last two items of the stream (entries and drain bubbles)
  fifo_entry_s win[$];
  fifo_entry_s m_lc, item;
  bit          m_drn, m_done;
  int unsigned m_cnt;

  initial begin
    logic pres, ok, inr_e, acc, hs_e, old_nc_v;

    tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0,   16'd0};
    tbl[1] = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,   32'h100, 32'h0,   16'd0};
    tbl[2] = '{1'b1, 32'h108, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h104, 32'h0,   16'd0};
    tbl[3] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 32'h108, 32'h100, 16'd1};
    tbl[4] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h108, 32'h100, 16'd2};
    tbl[5] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h108, 32'h100, 16'd2};
    tbl[6] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h108, 32'h100, 16'd2};
    tbl[7] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h108, 32'h0,   32'h104, 16'd2};
    tbl[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h108, 16'd3};
    tbl[9] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h108, 16'd3};

    rst_n = 1'b0; in_valid = 1'b0; drain = 1'b0; out_ready = 1'b1; in_entry = '0;
    #12;
    chk1("rst.wv", wv, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.inr", in_ready, 1'b1);
    chk32("rst.cnt", 32'(cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table: 0x100/0x104/0x108 stream, stall, drain, idle drain
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].pc, tbl[i].dr, tbl[i].ordy);
      chk1($sformatf("v%0d.wv", i), wv, tbl[i].wv);
      chk1($sformatf("v%0d.inr", i), in_ready, tbl[i].inr);
      chk1($sformatf("v%0d.busy", i), busy, tbl[i].busy);
      chk1($sformatf("v%0d.ncv", i), nc_o.valid, tbl[i].ncv);
      chk32($sformatf("v%0d.tc", i), tc_o.pc, tbl[i].tc);
      chk32($sformatf("v%0d.nc", i), nc_o.pc, tbl[i].nc);
      chk32($sformatf("v%0d.lc", i), lc_o.pc, tbl[i].lc);
      chk32($sformatf("v%0d.cnt", i), 32'(cnt), 32'(tbl[i].cnt));
    end

    // backpressure, then drain from RUN with both entries unconsumed
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    drive(1'b1, 32'h204, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h208, 1'b0, 1'b0);
      chk1("bp.wv", wv, 1'b1);
      chk1("bp.inr", in_ready, 1'b0);
      chk32("bp.tc", tc_o.pc, 32'h200);
      chk32("bp.lc", lc_o.pc, 32'h108);
    end
    drive(1'b1, 32'h208, 1'b0, 1'b1);
    chk1("rel.wv", wv, 1'b1);
    chk1("rel.inr", in_ready, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("dr0.wv", wv, 1'b1);
    chk32("dr0.tc", tc_o.pc, 32'h204);
    chk32("dr0.cnt", 32'(cnt), 32'd4);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("dr1.busy", busy, 1'b1);
    chk1("dr1.wv", wv, 1'b0);
    chk1("dr1.inr", in_ready, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("dr2.wv", wv, 1'b1);
    chk32("dr2.tc", tc_o.pc, 32'h208);
    chk1("dr2.ncv", nc_o.valid, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("dr3.busy", busy, 1'b0);
    chk32("dr3.lc", lc_o.pc, 32'h208);
    chk32("dr3.cnt", 32'(cnt), 32'd6);

    // single entry then drain from PRIME
    drive(1'b1, 32'h300, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk1("pr0.busy", busy, 1'b1);
    chk1("pr0.wv", wv, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("pr1.wv", wv, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("pr2.wv", wv, 1'b1);
    chk32("pr2.tc", tc_o.pc, 32'h300);
    chk1("pr2.ncv", nc_o.valid, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("pr3.busy", busy, 1'b0);
    chk32("pr3.cnt", 32'(cnt), 32'd7);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      chk1("idr.busy", busy, 1'b0);
      chk1("idr.wv", wv, 1'b0);
      chk32("idr.cnt", 32'(cnt), 32'd7);
    end

    // asynchronous reset in the middle of DRAIN
    drive(1'b1, 32'h400, 1'b0, 1'b1);
    drive(1'b1, 32'h404, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("ar.pre", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("ar.wv", wv, 1'b0);
    chk1("ar.busy", busy, 1'b0);
    chk1("ar.inr", in_ready, 1'b1);
    chk32("ar.cnt", 32'(cnt), 32'd0);
    chkE("ar.tc", tc_o, '0);
    chkE("ar.lc", lc_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h500, 1'b0, 1'b1);
    chk1("ar1.busy", busy, 1'b0);
    drive(1'b1, 32'h504, 1'b0, 1'b1);
    chk1("ar2.busy", busy, 1'b1);
    chk1("ar2.wv", wv, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("ar3.wv", wv, 1'b1);
    chk32("ar3.tc", tc_o.pc, 32'h500);
    chk32("ar3.nc", nc_o.pc, 32'h504);
    chk32("ar3.lc", lc_o.pc, 32'h0);

    // counter wrap: 18 entries give 17 handshakes
    do_reset();
    for (int i = 0; i < 18; i++) drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk32("wrap.cnt16", 32'(cnt), 32'd17);
    chk32("wrap.cnt4", 32'(cnt4), 32'd1);

    // random traffic against the queue model
    do_reset();
    win.delete();
    win.push_back('0);
    win.push_back('0);
    m_lc = '0; m_drn = 1'b0; m_done = 1'b0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid       = ($urandom_range(0, 9) < 7);
      drain          = ($urandom_range(0, 9) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      in_entry.valid = 1'($urandom_range(0, 1));
      in_entry.itype = 4'($urandom_range(0, 15));
      in_entry.pc    = $urandom;
      in_entry.tval  = $urandom;
      #1;
      pres  = win[0].valid && (win[1].valid || m_drn) && !m_done;
      ok    = !pres || out_ready;
      inr_e = !m_drn && ok;
      acc   = in_valid && inr_e;
      hs_e  = pres && out_ready;
      chk1("rnd.wv", wv, pres);
      chk1("rnd.inr", in_ready, inr_e);
      chk1("rnd.busy", busy, m_drn || win[0].valid || win[1].valid);
      chkE("rnd.tc", tc_o, win[0]);
      chkE("rnd.nc", nc_o, win[1]);
      chkE("rnd.lc", lc_o, m_lc);
      chk32("rnd.cnt", 32'(cnt), 32'(m_cnt % 65536));
      chk32("rnd.cnt4", 32'(cnt4), 32'(m_cnt % 16));
      old_nc_v = win[1].valid;
      if (hs_e) m_cnt++;
      if (acc || (m_drn && ok)) begin
        item = '0;
        if (acc) begin
          item = in_entry;
          item.valid = 1'b1;
        end
        if (win[0].valid) m_lc = win[0];
        void'(win.pop_front());
        win.push_back(item);
        m_done = 1'b0;
        if (m_drn && !old_nc_v) m_drn = 1'b0;
      end else begin
        if (hs_e) m_done = 1'b1;
        if (!m_drn && drain && !in_valid && (win[0].valid || win[1].valid)) m_drn = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
